// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial digit arithmetic block.
// Operation mode encoding and the width of the digit-count output.
package serial_arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int len_w(input int max_digits);
    return $clog2(max_digits + 1);
  endfunction

endpackage

// File: rtl/serial_digit_alu.sv
// Combinational single-digit adder/subtractor.
// Exposes the carry out of the MSB and the carry into the MSB, which are used to detect overflow.
module serial_digit_alu
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  op_e                mode,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               c_out,
  output logic               c_msb
);

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   total;

  // The carry into the MSB is recovered from the MSB sum bit, so DIGIT_W=1 needs no special case.
  always_comb begin
    b_eff = (mode == OP_SUB) ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    sum   = total[DIGIT_W-1:0];
    c_out = total[DIGIT_W];
    c_msb = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ total[DIGIT_W-1];
  end

endmodule

// File: rtl/serial_add_sub_digit.sv
// Serial LSB-first adder/subtractor for words of any length, with one registered result digit per beat.
// Word-level carry, signed overflow and the digit count are reported with the final digit.
module serial_add_sub_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vld,
  input  logic [DIGIT_W-1:0]               a,
  input  logic [DIGIT_W-1:0]               b,
  input  logic                             sub,
  input  logic                             last,
  output logic                             sum_vld,
  output logic [DIGIT_W-1:0]               sum,
  output logic                             sum_last,
  output logic                             carry,
  output logic                             ovf,
  output logic [len_w(MAX_DIGITS)-1:0]     len,
  output logic                             too_long
);

  localparam int LW = len_w(MAX_DIGITS);
  localparam logic [LW:0] MAX_EXT = (LW + 1)'(MAX_DIGITS);

  logic          first;
  op_e           mode;
  logic          cy;
  logic [LW-1:0] count;

  op_e            cur_mode;
  logic           cin;
  logic [DIGIT_W-1:0] alu_sum;
  logic           c_out;
  logic           c_msb;
  logic [LW:0]    next_cnt;
  logic           over;
  logic [LW-1:0]  sat_cnt;

  // The first beat of a word takes its mode from the input; later beats use the latched copy.
  always_comb begin
    cur_mode = first ? op_e'(sub) : mode;
    cin      = first ? sub : cy;
    next_cnt = {1'b0, count} + 1'b1;
    over     = next_cnt > MAX_EXT;
    sat_cnt  = over ? MAX_EXT[LW-1:0] : next_cnt[LW-1:0];
  end

  serial_digit_alu #(
    .DIGIT_W(DIGIT_W)
  ) u_alu (
    .a     (a),
    .b     (b),
    .mode  (cur_mode),
    .cin   (cin),
    .sum   (alu_sum),
    .c_out (c_out),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      first    <= 1'b1;
      mode     <= OP_ADD;
      cy       <= 1'b0;
      count    <= '0;
      sum_vld  <= 1'b0;
      sum      <= '0;
      sum_last <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      len      <= '0;
      too_long <= 1'b0;
    end else begin
      sum_vld  <= vld;
      sum      <= '0;
      sum_last <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      len      <= '0;
      too_long <= 1'b0;
      if (vld) begin
        sum      <= alu_sum;
        sum_last <= last;
        mode     <= cur_mode;
        // A final beat reports word status and rearms for the next word.
        if (last) begin
          carry    <= c_out;
          ovf      <= c_msb ^ c_out;
          len      <= sat_cnt;
          too_long <= over;
          first    <= 1'b1;
          count    <= '0;
          cy       <= 1'b0;
        end else begin
          first <= 1'b0;
          cy    <= c_out;
          count <= sat_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub_digit.sv
// Scoreboard bench for serial_add_sub_digit: expectations are derived from whole-number arithmetic
// on the accumulated operand prefixes and popped by an independent output monitor.
module tb_serial_add_sub_digit;

  localparam int W  = 4;
  localparam int MD = 8;
  localparam int LW = $clog2(MD + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          last;
  logic          sum_vld;
  logic [W-1:0]  sum;
  logic          sum_last;
  logic          carry;
  logic          ovf;
  logic [LW-1:0] len;
  logic          too_long;

  typedef struct {
    logic [W-1:0]  sum;
    logic          last;
    logic          carry;
    logic          ovf;
    logic [LW-1:0] len;
    logic          too_long;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  logic [63:0] m_a, m_b;
  int          m_n;
  logic        m_mode;
  logic        m_in_word = 1'b0;

  serial_add_sub_digit #(.DIGIT_W(W), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .sub(sub), .last(last),
    .sum_vld(sum_vld), .sum(sum), .sum_last(sum_last), .carry(carry),
    .ovf(ovf), .len(len), .too_long(too_long)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: digit i of the result is digit i of (A op B) over the digits seen so far.
  task automatic applyStimulus(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic s, input logic l);
    exp_t        e;
    logic [63:0] res;
    longint      sa, sb, r, lim;
    int          nw;
    @(negedge clk);
    vld = v; a = av; b = bv; sub = s; last = l;
    if (!v) return;
    if (!m_in_word) begin
      m_mode = s; m_a = '0; m_b = '0; m_n = 0; m_in_word = 1'b1;
    end
    m_a = m_a | (64'(av) << (m_n * W));
    m_b = m_b | (64'(bv) << (m_n * W));
    m_n++;
    nw  = m_n * W;
    res = m_mode ? (m_a - m_b) : (m_a + m_b);
    e.sum = W'(res >> ((m_n - 1) * W));
    e.last = l;
    e.carry = 1'b0; e.ovf = 1'b0; e.len = '0; e.too_long = 1'b0;
    if (l) begin
      e.carry = m_mode ? (m_a >= m_b) : res[nw];
      lim = longint'(1) << (nw - 1);
      sa = m_a[nw-1] ? longint'(m_a) - (lim << 1) : longint'(m_a);
      sb = m_b[nw-1] ? longint'(m_b) - (lim << 1) : longint'(m_b);
      r  = m_mode ? sa - sb : sa + sb;
      e.ovf = (r >= lim) || (r < -lim);
      e.len = LW'((m_n > MD) ? MD : m_n);
      e.too_long = m_n > MD;
      m_in_word = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_in_word = 1'b0;
  endtask

  // Monitor: compares each valid result beat against the oldest expectation; idle beats must be all zero.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sum_vld) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("sum", sum, e.sum);
            checkOutput("sum_last", sum_last, e.last);
            checkOutput("carry", carry, e.carry);
            checkOutput("ovf", ovf, e.ovf);
            checkOutput("len", len, e.len);
            checkOutput("too_long", too_long, e.too_long);
          end
        end else begin
          checkOutput("idle_zero", {sum, sum_last, carry, ovf, len, too_long}, 0);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0; vld = 1'b0; a = '0; b = '0; sub = 1'b0; last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", {sum_vld, sum, sum_last, carry, ovf, len, too_long}, 0);
    rst = 1'b1;
    mon_en = 1'b1;

    $display("[TB] directed: add, sub, single digit");
    applyStimulus(1, 4'h2, 4'h4, 0, 0);
    applyStimulus(1, 4'h1, 4'h3, 0, 1);
    applyStimulus(1, 4'h0, 4'h1, 1, 0);
    applyStimulus(1, 4'h1, 4'h0, 1, 1);
    applyStimulus(1, 4'h7, 4'h1, 0, 1);
    applyStimulus(1, 4'h8, 4'h1, 1, 1);

    $display("[TB] directed: gaps with sub toggling");
    applyStimulus(1, 4'h2, 4'h4, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 1, 1);
    applyStimulus(0, 4'h0, 4'h0, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 1, 1);
    applyStimulus(1, 4'h1, 4'h3, 1, 1);

    $display("[TB] directed: reset mid-word");
    applyStimulus(1, 4'hF, 4'h1, 0, 0);
    doReset();
    applyStimulus(1, 4'h0, 4'h0, 0, 1);

    $display("[TB] directed: overlong word");
    for (int i = 0; i < 10; i++) applyStimulus(1, 4'h0, 4'h0, 0, i == 9);
    applyStimulus(1, 4'h0, 4'h0, 0, 1);

    $display("[TB] random words");
    for (int w = 0; w < 60; w++) begin
      n = $urandom_range(1, 12);
      for (int d = 0; d < n; d++) begin
        applyStimulus(1, W'($urandom), W'($urandom), 1'($urandom), d == n - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end

    idle(4);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
